// File: rtl/div_pkg.sv
// Shared definitions for the divide stage: default width, FSM state encoding
// and the quotient pattern reported on a zero divisor.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/udiv_core.sv
// Combinational unsigned restoring divider, one quotient bit per unrolled step.
module udiv_core
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH:0]   part_s;
  logic [WIDTH-1:0] quo_s;

  // Shift-subtract-restore across all dividend bits; a zero divisor yields all-ones quotient.
  always_comb begin
    part_s = {(WIDTH+1){1'b0}};
    quo_s  = {WIDTH{1'b0}};
    for (int i = WIDTH-1; i >= 0; i--) begin
      part_s = {part_s[WIDTH-1:0], dividend[i]};
      if (part_s >= {1'b0, divisor}) begin
        part_s   = part_s - {1'b0, divisor};
        quo_s[i] = 1'b1;
      end else begin
        quo_s[i] = 1'b0;
      end
    end
    quotient  = quo_s;
    remainder = part_s[WIDTH-1:0];
  end

endmodule

// File: rtl/signed_div_stage.sv
// Handshaked divide stage (IDLE -> PREP -> FIX -> DONE) around udiv_core.
// Define SIGNED_DIV_EN to honour in_signed; otherwise every operation is unsigned.
module signed_div_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DBZ_C  = {WIDTH{DIV_DBZ_QUOTIENT[0]}};

  div_state_t       state_r;
  logic [WIDTH-1:0] dividend_r, divisor_r;
  logic [WIDTH-1:0] mag_a_r, mag_b_r;
  logic             q_neg_r, r_neg_r, dbz_r, ovf_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             in_ready_r, out_valid_r, dbz_out_r, ovf_out_r;

  logic [WIDTH-1:0] mag_a_s, mag_b_s, q_mag_s, r_mag_s, q_fix_s, r_fix_s;
  logic             a_neg_s, b_neg_s, dbz_s, ovf_s;

`ifdef SIGNED_DIV_EN
  localparam logic [WIDTH-1:0] MIN_C = {1'b1, {(WIDTH-1){1'b0}}};
  logic signed_r;

  // Capture the operation mode alongside the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      signed_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && in_valid) begin
      signed_r <= in_signed;
    end else begin
      signed_r <= signed_r;
    end
  end
`else
  logic unused_in_signed_s;
  assign unused_in_signed_s = in_signed;
`endif

  // Operand signs, magnitudes and corner-case flags; min-int negates to 2^(WIDTH-1) unsigned.
  always_comb begin
    dbz_s = (divisor_r == ZERO_C);
`ifdef SIGNED_DIV_EN
    a_neg_s = signed_r & dividend_r[WIDTH-1];
    b_neg_s = signed_r & divisor_r[WIDTH-1];
    ovf_s   = signed_r & (dividend_r == MIN_C) & (divisor_r == {WIDTH{1'b1}});
`else
    a_neg_s = 1'b0;
    b_neg_s = 1'b0;
    ovf_s   = 1'b0;
`endif
    if (a_neg_s) begin
      mag_a_s = ~dividend_r + ONE_C;
    end else begin
      mag_a_s = dividend_r;
    end
    if (b_neg_s) begin
      mag_b_s = ~divisor_r + ONE_C;
    end else begin
      mag_b_s = divisor_r;
    end
  end

  udiv_core #(.WIDTH(WIDTH)) u_udiv_core (
    .dividend  (mag_a_r),
    .divisor   (mag_b_r),
    .quotient  (q_mag_s),
    .remainder (r_mag_s)
  );

  // Re-apply signs to the unsigned result, with zero-divisor and overflow overrides.
  always_comb begin
    if (dbz_r) begin
      q_fix_s = DBZ_C;
      r_fix_s = dividend_r;
    end else if (ovf_r) begin
      q_fix_s = dividend_r;
      r_fix_s = ZERO_C;
    end else begin
      if (q_neg_r) begin
        q_fix_s = ~q_mag_s + ONE_C;
      end else begin
        q_fix_s = q_mag_s;
      end
      if (r_neg_r) begin
        r_fix_s = ~r_mag_s + ONE_C;
      end else begin
        r_fix_s = r_mag_s;
      end
    end
  end

  // Stage FSM and all pipeline/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      dividend_r  <= ZERO_C;
      divisor_r   <= ZERO_C;
      mag_a_r     <= ZERO_C;
      mag_b_r     <= ZERO_C;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      quotient_r  <= ZERO_C;
      remainder_r <= ZERO_C;
      dbz_out_r   <= 1'b0;
      ovf_out_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            dividend_r <= Dividend;
            divisor_r  <= Divisor;
            in_ready_r <= 1'b0;
            state_r    <= ST_PREP;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_PREP: begin
          mag_a_r <= mag_a_s;
          mag_b_r <= mag_b_s;
          q_neg_r <= a_neg_s ^ b_neg_s;
          r_neg_r <= a_neg_s;
          dbz_r   <= dbz_s;
          ovf_r   <= ovf_s;
          state_r <= ST_FIX;
        end
        ST_FIX: begin
          quotient_r  <= q_fix_s;
          remainder_r <= r_fix_s;
          dbz_out_r   <= dbz_r;
          ovf_out_r   <= ovf_r;
          out_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign Quotient    = quotient_r;
  assign Remainder   = remainder_r;
  assign div_by_zero = dbz_out_r;
  assign overflow    = ovf_out_r;

endmodule

// File: tb/tb_signed_div_stage.sv
// Randomized self-checking bench for signed_div_stage against an arithmetic reference model.
// Signed expectations apply only when SIGNED_DIV_EN is defined for the build.
module tb_signed_div_stage;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_signed, out_ready;
  logic         in_ready, out_valid, div_by_zero, overflow;
  logic [W-1:0] Dividend, Divisor, Quotient, Remainder;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  signed_div_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .Dividend(Dividend), .Divisor(Divisor),
    .out_valid(out_valid), .out_ready(out_ready), .Quotient(Quotient),
    .Remainder(Remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  // Reference: plain integer division with the defined corner cases.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    bit sg;
    int sa, sb;
`ifdef SIGNED_DIV_EN
    sg = s;
`else
    sg = 1'b0;
`endif
    dz = 1'b0; ov = 1'b0;
    sa = a; sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (sg && a == MIN_V && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0; ov = 1'b1;
    end else if (sg) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Issue one op from a negedge; return observed result, latency and accept cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov, output int lat, output int acc);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin @(negedge clk); n++; end
    Dividend = a; Divisor = b; in_signed = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; acc = cyc; lat = 1;
    while (!out_valid && lat < 12) begin @(negedge clk); lat++; end
    q = Quotient; r = Remainder; dz = div_by_zero; ov = overflow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_signed = 1'b0;
    Dividend = 32'd55; Divisor = 32'd5;
    repeat (3) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (Quotient !== 32'd0 || Remainder !== 32'd0) begin miscompares++; $display("FAIL reset_data: got %h/%h expected 0/0", Quotient, Remainder); end
    vectors++; if ({div_by_zero, overflow} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b expected 00", {div_by_zero, overflow}); end
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release: got v=%b r=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_directed;
    logic [W-1:0] da [5], db [5];
    logic         ds [5];
    logic [W-1:0] q, r, eq, er;
    logic         dz, ov, edz, eov;
    int           lat, acc;
    da = '{32'd100, 32'hFFFF_FFF9, 32'h1234, MIN_V, MIN_V};
    db = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ds = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_op(da[i], db[i], ds[i], q, r, dz, ov, lat, acc);
      model(da[i], db[i], ds[i], eq, er, edz, eov);
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL dir%0d_latency: got %0d expected 3", i, lat); end
      vectors++; if (q !== eq || r !== er) begin miscompares++; $display("FAIL dir%0d_result: got %h/%h expected %h/%h", i, q, r, eq, er); end
      vectors++; if ({dz, ov} !== {edz, eov}) begin miscompares++; $display("FAIL dir%0d_flags: got %b expected %b", i, {dz, ov}, {edz, eov}); end
      if (i == 0) begin
        vectors++; if (q !== 32'd14 || r !== 32'd2 || {dz, ov} !== 2'b00) begin miscompares++; $display("FAIL u100_7: got %0d/%0d expected 14/2", q, r); end
      end else if (i == 2) begin
        vectors++; if (q !== 32'hFFFF_FFFF || r !== 32'h1234 || dz !== 1'b1 || ov !== 1'b0) begin miscompares++; $display("FAIL dbz_const: got %h/%h dz=%b expected ffffffff/1234 dz=1", q, r, dz); end
      end else if (i == 4) begin
        vectors++; if (q !== 32'd0 || r !== MIN_V || ov !== 1'b0) begin miscompares++; $display("FAIL min_m1_unsigned: got %h/%h ov=%b expected 0/80000000 ov=0", q, r, ov); end
`ifdef SIGNED_DIV_EN
      end else if (i == 1) begin
        vectors++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL s_m7_2: got %h/%h expected fffffffd/ffffffff", q, r); end
      end else if (i == 3) begin
        vectors++; if (q !== MIN_V || r !== 32'd0 || ov !== 1'b1) begin miscompares++; $display("FAIL min_m1_signed: got %h/%h ov=%b expected 80000000/0 ov=1", q, r, ov); end
`endif
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, q, r, eq, er;
    logic         s, dz, ov, edz, eov;
    int           lat, acc, k;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 5);
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (k == 0) b = 32'd0;
      else if (k == 1) begin a = MIN_V; b = 32'hFFFF_FFFF; end
      else if (k == 2) b = 32'($urandom_range(1, 15));
      else if (k == 3) b = -32'($urandom_range(1, 15));
      do_op(a, b, s, q, r, dz, ov, lat, acc);
      model(a, b, s, eq, er, edz, eov);
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d expected 3", i, lat); end
      vectors++; if (q !== eq) begin miscompares++; $display("FAIL rnd%0d_quotient: %h/%h s=%b got %h expected %h", i, a, b, s, q, eq); end
      vectors++; if (r !== er) begin miscompares++; $display("FAIL rnd%0d_remainder: %h/%h s=%b got %h expected %h", i, a, b, s, r, er); end
      vectors++; if ({dz, ov} !== {edz, eov}) begin miscompares++; $display("FAIL rnd%0d_flags: got %b expected %b", i, {dz, ov}, {edz, eov}); end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] eq, er, q, r;
    logic         edz, eov, dz, ov;
    int           n, lat, acc;
    model(32'd1000, 32'hFFFF_FFFD, 1'b1, eq, er, edz, eov);
    Dividend = 32'd1000; Divisor = 32'hFFFF_FFFD; in_signed = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; n = 0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; Dividend = $urandom; Divisor = 32'd3;
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL hold%0d_handshake: got v=%b r=%b expected 1/0", i, out_valid, in_ready); end
      vectors++; if (Quotient !== eq || Remainder !== er || {div_by_zero, overflow} !== {edz, eov}) begin miscompares++; $display("FAIL hold%0d_stable: got %h/%h expected %h/%h", i, Quotient, Remainder, eq, er); end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL release_idle: got v=%b r=%b expected 0/1", out_valid, in_ready); end
    do_op(32'd77, 32'd8, 1'b0, q, r, dz, ov, lat, acc);
    vectors++; if (q !== 32'd9 || r !== 32'd5 || lat !== 3) begin miscompares++; $display("FAIL after_hold: got %0d/%0d lat %0d expected 9/5 lat 3", q, r, lat); end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] q, r;
    logic         dz, ov, seen;
    int           lat, acc;
    Dividend = 32'd500; Divisor = 32'd9; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || Quotient !== 32'd0) begin miscompares++; $display("FAIL rst_prep: got v=%b r=%b q=%h expected 0/1/0", out_valid, in_ready, Quotient); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    out_ready = 1'b0;
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_no_result: got %b expected 0", seen); end
    do_op(32'd500, 32'd9, 1'b0, q, r, dz, ov, lat, acc);
    vectors++; if (q !== 32'd55 || r !== 32'd5) begin miscompares++; $display("FAIL rst_recover: got %0d/%0d expected 55/5", q, r); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b, q, r, eq, er;
    logic         dz, ov, edz, eov;
    int           lat, acc, prev;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = 32'($urandom_range(1, 1000));
      do_op(a, b, 1'b0, q, r, dz, ov, lat, acc);
      model(a, b, 1'b0, eq, er, edz, eov);
      vectors++; if (q !== eq || r !== er) begin miscompares++; $display("FAIL b2b%0d_result: got %h/%h expected %h/%h", i, q, r, eq, er); end
      if (prev >= 0) begin
        vectors++; if (acc - prev !== 4) begin miscompares++; $display("FAIL b2b%0d_spacing: got %0d expected 4", i, acc - prev); end
      end
      prev = acc;
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; in_signed = 1'b0; rst = 1'b1;
    Dividend = 32'd0; Divisor = 32'd0;
    @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/signed_div_stage.md
SIGNED_DIV_STAGE -- requirements
Module: signed_div_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept a request.
REQ-006 SHALL have port in_signed  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-007 SHALL have port Dividend  input  WIDTH  dividend operand.
REQ-008 SHALL have port Divisor  input  WIDTH  divisor operand.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port Quotient  output  WIDTH  final quotient.
REQ-012 SHALL have port Remainder  output  WIDTH  final remainder.
REQ-013 SHALL have port div_by_zero  output  1  divisor was zero.
REQ-014 SHALL have port overflow  output  1  signed min/-1 overflow.

Function
REQ-015 SHALL implement FSM IDLE -> PREP -> FIX -> DONE -> IDLE.
REQ-016 IDLE: in_ready=1; in_valid&in_ready registers Dividend, Divisor, in_signed; go to PREP.
REQ-017 PREP: register operand magnitudes (negate negative signed operands), quotient sign (sign XOR), remainder sign (dividend sign), zero/overflow flags; go to FIX.
REQ-018 FIX: feed registered magnitudes to unsigned divide core, apply signs, register Quotient/Remainder/flags; go to DONE.
REQ-019 DONE: out_valid=1; outputs held stable until out_valid&out_ready, then IDLE.
REQ-020 Latency SHALL be 3 cycles from accept edge to out_valid high; throughput one op per 4 cycles minimum.
REQ-021 in_ready SHALL be 0 in PREP, FIX, DONE; no request accepted while result pending.
REQ-022 Signed results SHALL truncate toward zero; nonzero Remainder takes Dividend's sign.
REQ-023 Divisor=0: Quotient=all ones, Remainder=Dividend, div_by_zero=1, overflow=0 (both modes).
REQ-024 Signed Dividend=most-negative, Divisor=-1: Quotient=Dividend, Remainder=0, overflow=1.
REQ-025 Magnitude of most-negative value SHALL be handled as unsigned 2^(WIDTH-1), no extra bit lost.
REQ-026 Flags SHALL be 0 for all other operands; flags valid only with out_valid.

Reset
REQ-027 rst SHALL force IDLE, in_ready=1, out_valid=0, Quotient=0, Remainder=0, div_by_zero=0, overflow=0.
REQ-028 rst in any state SHALL discard in-flight operation; rst dominates simultaneous in_valid/out_ready.

Configuration
REQ-029 Macro SIGNED_DIV_EN defined: in_signed honoured per REQ-017..025.
REQ-030 SIGNED_DIV_EN undefined: in_signed ignored, all ops unsigned, overflow tied 0, sign logic removed.

Structure
REQ-031 Shared package div_pkg SHALL hold WIDTH default, FSM state enum, div-by-zero quotient constant.
REQ-032 Sub-module udiv_core (combinational unsigned restoring divide, WIDTH-bit) SHALL be instantiated once in FIX path.

Verification
REQ-033 Unsigned 100/7 accepted cycle 0 -> out_valid cycle 3, Quotient=14, Remainder=2, flags 0.
REQ-034 Signed -7/2 (0xFFFFFFF9/0x2) -> Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF.
REQ-035 0x1234/0 -> Quotient=0xFFFFFFFF, Remainder=0x1234, div_by_zero=1.
REQ-036 0x80000000/0xFFFFFFFF signed -> Quotient=0x80000000, Remainder=0, overflow=1; unsigned -> Quotient=0, Remainder=0x80000000, overflow=0.
REQ-037 out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.
REQ-038 rst asserted during PREP -> next cycle IDLE, out_valid=0, no result ever emitted for that op.
